// File: rtl/draw_ball.sv
// rtl/draw_ball.sv - two-stage VGA overlay drawing a 16x16 ball at a frame-latched position.
// Optional round ball shape: define DRAW_BALL_ROUND_EN.
module draw_ball #(
    parameter int          BALL_SIZE  = 16,
    parameter logic [11:0] BALL_COLOR = 12'hFFF
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [11:0] XPOS_RST = 12'd512;
    localparam logic [11:0] YPOS_RST = 12'd0;
    localparam logic [12:0] BOX_MAX  = 13'(BALL_SIZE - 1);

    logic        vblnk_prev_q;
    logic [11:0] xpos_l_q, ypos_l_q;
    logic        latch_en;

    logic [12:0] dx_d, dy_d;
    logic [12:0] dx_q, dy_q;
    logic [10:0] hcount1_q, vcount1_q;
    logic        hsync1_q, vsync1_q, hblnk1_q, vblnk1_q;
    logic [11:0] rgb1_q;

    logic        in_box;
    logic        mask;
    logic [11:0] rgb_d;

    logic [10:0] hcount2_q, vcount2_q;
    logic        hsync2_q, vsync2_q, hblnk2_q, vblnk2_q;
    logic [11:0] rgb2_q;

    // Position only moves on the vblank rising edge so a frame never tears.
    assign latch_en = vblnk_in && !vblnk_prev_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_prev_q <= 1'b0;
            xpos_l_q     <= XPOS_RST;
            ypos_l_q     <= YPOS_RST;
        end else begin
            vblnk_prev_q <= vblnk_in;
            if (latch_en) begin
                xpos_l_q <= xpos;
                ypos_l_q <= ypos;
            end
        end
    end

    // 13-bit difference: positions >= 2048 always give a negative dx/dy.
    always_comb begin
        dx_d = {2'b00, hcount_in} - {1'b0, xpos_l_q};
        dy_d = {2'b00, vcount_in} - {1'b0, ypos_l_q};
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            dx_q      <= '0;
            dy_q      <= '0;
            hcount1_q <= '0;
            vcount1_q <= '0;
            hsync1_q  <= 1'b0;
            vsync1_q  <= 1'b0;
            hblnk1_q  <= 1'b0;
            vblnk1_q  <= 1'b0;
            rgb1_q    <= '0;
        end else begin
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            hcount1_q <= hcount_in;
            vcount1_q <= vcount_in;
            hsync1_q  <= hsync_in;
            vsync1_q  <= vsync_in;
            hblnk1_q  <= hblnk_in;
            vblnk1_q  <= vblnk_in;
            rgb1_q    <= rgb_in;
        end
    end

    assign in_box = !dx_q[12] && (dx_q <= BOX_MAX) && !dy_q[12] && (dy_q <= BOX_MAX);

`ifdef DRAW_BALL_ROUND_EN
    // |2d-15|^2 for an in-box offset d in 0..15.
    function automatic logic [9:0] centred_sq(input logic [3:0] d);
        logic [4:0] two_d;
        logic [4:0] a;
        two_d = {d, 1'b0};
        a     = d[3] ? (two_d - 5'd15) : (5'd15 - two_d);
        return {6'b0, a[3:0]} * {6'b0, a[3:0]};
    endfunction

    logic [9:0] dist_sum;
    assign dist_sum = centred_sq(dx_q[3:0]) + centred_sq(dy_q[3:0]);
    assign mask     = (dist_sum <= 10'd256);
`else
    assign mask = 1'b1;
`endif

    always_comb begin
        rgb_d = rgb1_q;
        if (hblnk1_q || vblnk1_q) begin
            rgb_d = 12'h000;
        end else if (in_box && mask) begin
            rgb_d = BALL_COLOR;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount2_q <= '0;
            vcount2_q <= '0;
            hsync2_q  <= 1'b0;
            vsync2_q  <= 1'b0;
            hblnk2_q  <= 1'b0;
            vblnk2_q  <= 1'b0;
            rgb2_q    <= '0;
        end else begin
            hcount2_q <= hcount1_q;
            vcount2_q <= vcount1_q;
            hsync2_q  <= hsync1_q;
            vsync2_q  <= vsync1_q;
            hblnk2_q  <= hblnk1_q;
            vblnk2_q  <= vblnk1_q;
            rgb2_q    <= rgb_d;
        end
    end

    assign hcount_out = hcount2_q;
    assign vcount_out = vcount2_q;
    assign hsync_out  = hsync2_q;
    assign vsync_out  = vsync2_q;
    assign hblnk_out  = hblnk2_q;
    assign vblnk_out  = vblnk2_q;
    assign rgb_out    = rgb2_q;

endmodule

// File: doc/draw_ball.md
DRAW_BALL -- requirements
Module: draw_ball

Interface
REQ-001 Parameter BALL_SIZE, default 16, ball bounding-box edge in pixels; only 16 is supported.
REQ-002 Parameter BALL_COLOR, default 12'hFFF, RGB444 colour of ball pixels.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low (ports pclk and rst_n).
REQ-004 pclk  input  1  pixel clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 hcount_in  input  11  horizontal pixel counter of incoming VGA stream.
REQ-007 vcount_in  input  11  vertical line counter of incoming VGA stream.
REQ-008 hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  incoming sync and blanking.
REQ-009 rgb_in  input  12  incoming background pixel colour.
REQ-010 xpos  input  12  ball top-left x from the ball controller, unsigned.
REQ-011 ypos  input  12  ball top-left y from the ball controller, unsigned.
REQ-012 hcount_out, vcount_out  output  11 each  hcount_in/vcount_in delayed 2 cycles.
REQ-013 hsync_out, vsync_out, hblnk_out, vblnk_out  output  1 each  inputs delayed 2 cycles.
REQ-014 rgb_out  output  12  composited pixel, aligned with the delayed timing outputs.

Function
REQ-015 Latency SHALL be exactly 2 pclk cycles from any input pixel to its output on every output port.
REQ-016 Frame latch: xpos_l/ypos_l SHALL load xpos/ypos only in the cycle where vblnk_in is 1 and the previous registered vblnk_in is 0 (rising edge); otherwise they hold.
REQ-017 Position changes outside that edge SHALL NOT affect the current frame (no tearing).
REQ-018 Stage 1 SHALL register dx = {2'b0,hcount_in} - {1'b0,xpos_l} and dy likewise from vcount_in/ypos_l as 13-bit signed, plus the delayed timing and rgb_in.
REQ-019 Stage 2 SHALL assert in_box when 0 <= dx <= 15 and 0 <= dy <= 15; negative or >15 values are outside.
REQ-020 Stage 2 SHALL register rgb_out = BALL_COLOR when in_box, mask true, and both stage-1 blanking bits are 0; else the stage-1 rgb.
REQ-021 During blanking, rgb_out SHALL be 12'h000 regardless of rgb_in or ball position.
REQ-022 Ball partially off-screen (xpos_l > 1008 or ypos_l > 752) SHALL draw only visible pixels; no wrap-around to column/line 0.
REQ-023 xpos/ypos >= 2048 SHALL produce no ball pixels (dx always negative), with no arithmetic overflow.
REQ-024 Latch edge coincident with a visible pixel (not possible in legal timing) SHALL still use the pre-edge position for that pixel.

Reset
REQ-025 rst_n low SHALL immediately clear all outputs to 0, rgb_out to 12'h000, pipeline registers to 0, vblnk edge register to 0.
REQ-026 rst_n low SHALL set xpos_l = 512, ypos_l = 0.
REQ-027 After release, the first latch SHALL occur at the first vblnk_in rising edge; a reset mid-frame discards the pipeline contents.

Configuration
REQ-028 Macro DRAW_BALL_ROUND_EN defined: mask SHALL be true iff (2*dx-15)^2 + (2*dy-15)^2 <= 256, using at least 10-bit unsigned squares and a 10-bit sum; corner pixels (0,0),(15,15) excluded.
REQ-029 DRAW_BALL_ROUND_EN undefined: mask SHALL be constant true, drawing the full 16x16 square; latency unchanged.

Verification
REQ-030 Reset: rst_n=0 mid-line -> all outputs 0 within the same cycle, no pclk needed; after release, latched position 512,0.
REQ-031 Latch: xpos=100, ypos=200 set mid-frame, changed to 300 before vblnk edge -> next frame draws at x 300..315, y 200..215; current frame unchanged.
REQ-032 Latency: rgb_in=12'h0F0, hcount_in=310 vcount_in=205 -> two cycles later hcount_out=310 and rgb_out=BALL_COLOR; pixel 316 -> 12'h0F0.
REQ-033 Blanking: ball at xpos=1020 -> pixels 1020..1023 coloured, hblnk columns 12'h000, column 0..3 of next line not coloured.
REQ-034 Round mask (macro defined): ball at 0,0 -> pixel (0,0) background, (7,0) and (0,7) ball, (15,15) background; macro undefined -> all 256 pixels ball.
REQ-035 Out of range: xpos=12'hFFF -> no ball pixel anywhere in frame, timing outputs match inputs delayed 2 cycles.
